// File: rtl/bram_arbiter.sv
// Two-port round-robin arbiter and sequencer for a single-port 32-bit BRAM.
// Issues one registered access per cycle and returns read data to the issuing port.
module bram_arbiter #(
  parameter int P_ADDR_BITS    = 14,
  parameter int P_READ_LATENCY = 2,
  parameter int P_CNT_BITS     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_req_valid,
  output logic                   a_req_ready,
  input  logic                   a_req_we,
  input  logic [P_ADDR_BITS-1:0] a_req_addr,
  input  logic [31:0]            a_req_wdata,
  output logic                   a_rsp_valid,
  output logic [31:0]            a_rsp_rdata,
  input  logic                   b_req_valid,
  output logic                   b_req_ready,
  input  logic                   b_req_we,
  input  logic [P_ADDR_BITS-1:0] b_req_addr,
  input  logic [31:0]            b_req_wdata,
  output logic                   b_rsp_valid,
  output logic [31:0]            b_rsp_rdata,
  output logic                   bram_en,
  output logic                   bram_wren,
  output logic [P_ADDR_BITS-1:0] bram_addr,
  output logic [31:0]            bram_d_in,
  input  logic [31:0]            bram_d_out,
  output logic [P_CNT_BITS-1:0]  conflict_cnt
);

  localparam int   DATA_W = 32;
  localparam int   L      = P_READ_LATENCY;
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  function automatic logic [P_CNT_BITS-1:0] sat_inc(input logic [P_CNT_BITS-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic                   rr_last_q, rr_last_d;
  logic                   a_grant, b_grant, hs;
  logic                   sel_we;
  logic [P_ADDR_BITS-1:0] sel_addr;
  logic [DATA_W-1:0]      sel_wdata;

  logic                   iss_vld_q, iss_vld_d;
  logic                   iss_we_q, iss_we_d;
  logic [P_ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]      din_q, din_d;

  logic [L:0]             tag_vld_q, tag_vld_d;
  logic [L:0]             tag_port_q, tag_port_d;
  logic [P_CNT_BITS-1:0]  cnt_q, cnt_d;

  // Grant: a lone requester wins; on a conflict the port that did not win last time goes.
  always_comb begin
    a_grant = 1'b0;
    b_grant = 1'b0;
    if (!rst) begin
      if (a_req_valid && b_req_valid) begin
        a_grant = (rr_last_q == PORT_B);
        b_grant = (rr_last_q == PORT_A);
      end else begin
        a_grant = a_req_valid;
        b_grant = b_req_valid;
      end
    end
  end

  assign a_req_ready = a_grant;
  assign b_req_ready = b_grant;
  assign hs          = a_grant | b_grant;

  always_comb begin
    sel_we    = b_grant ? b_req_we    : a_req_we;
    sel_addr  = b_grant ? b_req_addr  : a_req_addr;
    sel_wdata = b_grant ? b_req_wdata : a_req_wdata;
  end

  always_comb begin
    rr_last_d  = rr_last_q;
    iss_vld_d  = hs;
    iss_we_d   = hs & sel_we;
    addr_d     = addr_q;
    din_d      = din_q;
    tag_vld_d  = {tag_vld_q[L-1:0], hs & ~sel_we};
    tag_port_d = {tag_port_q[L-1:0], b_grant};
    cnt_d      = cnt_q;
    if (hs) begin
      rr_last_d = b_grant ? PORT_B : PORT_A;
      addr_d    = sel_addr;
      din_d     = sel_wdata;
    end
    if (a_req_valid && b_req_valid && !rst) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  // Issue stage: handshake registered, BRAM driven the following cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_q  <= PORT_B;
      iss_vld_q  <= 1'b0;
      iss_we_q   <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      tag_vld_q  <= '0;
      tag_port_q <= '0;
      cnt_q      <= '0;
    end else begin
      rr_last_q  <= rr_last_d;
      iss_vld_q  <= iss_vld_d;
      iss_we_q   <= iss_we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      tag_vld_q  <= tag_vld_d;
      tag_port_q <= tag_port_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bram_en      = iss_vld_q;
  assign bram_wren    = iss_we_q;
  assign bram_addr    = addr_q;
  assign bram_d_in    = din_q;
  assign conflict_cnt = cnt_q;

  // Return stage: oldest tag lines up with the BRAM output word
  always_comb begin
    a_rsp_valid = !rst && tag_vld_q[L] && (tag_port_q[L] == PORT_A);
    b_rsp_valid = !rst && tag_vld_q[L] && (tag_port_q[L] == PORT_B);
    a_rsp_rdata = a_rsp_valid ? bram_d_out : '0;
    b_rsp_rdata = b_rsp_valid ? bram_d_out : '0;
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: BRAM model, request drivers and a cycle-level reference scoreboard.
module tb_bram_arbiter;

  localparam int AW = 14;
  localparam int CW = 4;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wd;
  } req_t;

  typedef struct {
    int          cyc;
    logic [31:0] d;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_req_valid = 1'b0, a_req_we = 1'b0;
  logic [AW-1:0] a_req_addr = '0;
  logic [31:0]   a_req_wdata = '0;
  logic          b_req_valid = 1'b0, b_req_we = 1'b0;
  logic [AW-1:0] b_req_addr = '0;
  logic [31:0]   b_req_wdata = '0;
  logic          a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid;
  logic [31:0]   a_rsp_rdata, b_rsp_rdata;
  logic          bram_en, bram_wren;
  logic [AW-1:0] bram_addr;
  logic [31:0]   bram_d_in, bram_d_out;
  logic [CW-1:0] conflict_cnt;

  bram_arbiter #(.P_ADDR_BITS(AW), .P_READ_LATENCY(2), .P_CNT_BITS(CW)) dut (
    .clk(clk), .rst(rst),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
    .bram_en(bram_en), .bram_wren(bram_wren), .bram_addr(bram_addr),
    .bram_d_in(bram_d_in), .bram_d_out(bram_d_out), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [AW-1:0] a);
    return (a == 14'h10) ? 32'hDEADBEEF : (32'hC0DE0000 | {18'd0, a});
  endfunction

  // BRAM model, two-cycle read latency
  logic [31:0] mem [0:(1<<AW)-1];
  bit          mem_w [0:(1<<AW)-1];
  logic [31:0] rd_p1, rd_p2;

  always @(posedge clk) begin
    if (bram_en && bram_wren) begin
      mem[bram_addr]   <= bram_d_in;
      mem_w[bram_addr] <= 1'b1;
    end
    if (bram_en && !bram_wren) rd_p1 <= mem_w[bram_addr] ? mem[bram_addr] : init_val(bram_addr);
    rd_p2 <= rd_p1;
  end
  assign bram_d_out = rd_p2;

  // Reference state
  logic [31:0] sh [0:(1<<AW)-1];
  bit          sh_w [0:(1<<AW)-1];
  req_t aq[$], bq[$];
  rsp_t ra[$], rb[$];
  logic          m_rr = 1'b1;
  logic          m_en = 1'b0, m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [31:0]   m_din = '0;
  logic [CW-1:0] m_cnt = '0;
  int cyc = 0;
  int a_seen = 0, b_seen = 0;
  logic [31:0] last_b_data = '0;
  int en_run = 0, en_max = 0;

  function automatic logic [31:0] sh_rd(input logic [AW-1:0] a);
    return sh_w[a] ? sh[a] : init_val(a);
  endfunction

  // Request drivers: present the head of each queue until it is accepted
  initial forever begin
    @(posedge clk);
    #1;
    a_req_valid = (aq.size() > 0);
    if (aq.size() > 0) begin
      a_req_we = aq[0].we; a_req_addr = aq[0].addr; a_req_wdata = aq[0].wd;
    end
    b_req_valid = (bq.size() > 0);
    if (bq.size() > 0) begin
      b_req_we = bq[0].we; b_req_addr = bq[0].addr; b_req_wdata = bq[0].wd;
    end
  end

  // Monitor / scoreboard, sampled on the falling edge
  initial begin
    logic ga, gb;
    rsp_t r;
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc++;
      check("bram_en", 32'(bram_en), 32'(m_en));
      check("bram_wren", 32'(bram_wren), 32'(m_we));
      check("bram_addr", 32'(bram_addr), 32'(m_addr));
      check("bram_d_in", bram_d_in, m_din);
      check("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
      if (bram_en) begin
        en_run++;
        if (en_run > en_max) en_max = en_run;
      end else en_run = 0;
      if (a_rsp_valid) a_seen++;
      if (b_rsp_valid) begin
        b_seen++;
        last_b_data = b_rsp_rdata;
      end
      if (rst) begin
        check("rst_a_ready", 32'(a_req_ready), 0);
        check("rst_b_ready", 32'(b_req_ready), 0);
        check("rst_a_rsp_valid", 32'(a_rsp_valid), 0);
        check("rst_b_rsp_valid", 32'(b_rsp_valid), 0);
        ra.delete(); rb.delete();
        m_rr = 1'b1; m_cnt = '0; m_en = 1'b0; m_we = 1'b0; m_addr = '0; m_din = '0;
      end else begin
        if (ra.size() > 0 && ra[0].cyc == cyc) begin
          r = ra.pop_front();
          check("a_rsp_valid", 32'(a_rsp_valid), 1);
          check("a_rsp_rdata", a_rsp_rdata, r.d);
        end else begin
          check("a_rsp_idle_valid", 32'(a_rsp_valid), 0);
          check("a_rsp_idle_rdata", a_rsp_rdata, 0);
        end
        if (rb.size() > 0 && rb[0].cyc == cyc) begin
          r = rb.pop_front();
          check("b_rsp_valid", 32'(b_rsp_valid), 1);
          check("b_rsp_rdata", b_rsp_rdata, r.d);
        end else begin
          check("b_rsp_idle_valid", 32'(b_rsp_valid), 0);
          check("b_rsp_idle_rdata", b_rsp_rdata, 0);
        end
        ga = a_req_valid && (!b_req_valid || m_rr);
        gb = b_req_valid && (!a_req_valid || !m_rr);
        check("a_req_ready", 32'(a_req_ready), 32'(ga));
        check("b_req_ready", 32'(b_req_ready), 32'(gb));
        if (a_req_valid && b_req_valid && m_cnt != '1) m_cnt = m_cnt + 1'b1;
        m_en = ga || gb;
        m_we = 1'b0;
        if (ga || gb) begin
          m_we   = ga ? a_req_we : b_req_we;
          m_addr = ga ? a_req_addr : b_req_addr;
          m_din  = ga ? a_req_wdata : b_req_wdata;
          if (m_we) begin
            sh[m_addr] = m_din;
            sh_w[m_addr] = 1'b1;
          end else if (ga) ra.push_back('{cyc + 3, sh_rd(m_addr)});
          else rb.push_back('{cyc + 3, sh_rd(m_addr)});
          m_rr = gb;
          if (ga) void'(aq.pop_front());
          else void'(bq.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((aq.size() + bq.size() + ra.size() + rb.size()) > 0 && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) check("drain_timeout", 32'(n), 0);
    repeat (3) step();
  endtask

  task automatic do_reset(input int n);
    step();
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  int a0, b0;

  initial begin
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;

    // single A read of the preloaded word
    a0 = a_seen; b0 = b_seen;
    aq.push_back('{1'b0, 14'h10, 32'h0});
    wait_idle(50);
    check("t1_a_rsp_count", 32'(a_seen - a0), 1);
    check("t1_b_rsp_count", 32'(b_seen - b0), 0);

    // sustained conflict right after reset
    do_reset(2);
    a0 = a_seen; b0 = b_seen;
    for (int i = 0; i < 3; i++) aq.push_back('{1'b0, AW'(14'h30 + i), 32'h0});
    for (int i = 0; i < 2; i++) bq.push_back('{1'b0, AW'(14'h40 + i), 32'h0});
    wait_idle(50);
    check("t2_conflict_cnt", 32'(conflict_cnt), 4);
    check("t2_a_rsp_count", 32'(a_seen - a0), 3);
    check("t2_b_rsp_count", 32'(b_seen - b0), 2);

    // read-after-write across ports
    aq.push_back('{1'b1, 14'h5, 32'h12345678});
    step();
    bq.push_back('{1'b0, 14'h5, 32'h0});
    wait_idle(50);
    check("t3_b_rdata", last_b_data, 32'h12345678);

    // back-to-back B stream
    b0 = b_seen;
    en_max = 0;
    for (int i = 0; i < 8; i++) bq.push_back('{1'b0, AW'(14'h100 + i), 32'h0});
    wait_idle(50);
    check("t4_b_rsp_count", 32'(b_seen - b0), 8);
    check("t4_en_run", 32'(en_max), 8);

    // reset with reads in flight
    a0 = a_seen;
    aq.push_back('{1'b0, 14'h20, 32'h0});
    aq.push_back('{1'b0, 14'h21, 32'h0});
    begin
      int n = 0;
      while (aq.size() > 0 && n < 50) begin step(); n++; end
      if (n >= 50) check("t5_issue_timeout", 32'(n), 0);
    end
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    check("t5_bram_en", 32'(bram_en), 0);
    check("t5_bram_wren", 32'(bram_wren), 0);
    check("t5_bram_addr", 32'(bram_addr), 0);
    check("t5_bram_d_in", bram_d_in, 0);
    check("t5_conflict_cnt", 32'(conflict_cnt), 0);
    repeat (6) step();
    check("t5_no_stale_rsp", 32'(a_seen - a0), 0);
    aq.push_back('{1'b0, 14'h50, 32'h0});
    bq.push_back('{1'b0, 14'h60, 32'h0});
    wait_idle(50);

    // counter saturation
    do_reset(2);
    for (int i = 0; i < 30; i++) begin
      aq.push_back('{1'b0, AW'(14'h200 + i), 32'h0});
      bq.push_back('{1'b0, AW'(14'h300 + i), 32'h0});
    end
    wait_idle(400);
    check("t6_conflict_sat", 32'(conflict_cnt), 32'hF);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
